// File: rtl/csr_counter_bank.sv
// Machine counter/timer CSR bank: mcycle, minstret, mhpmcounter3.., mcountinhibit and user shadows.
// Optional sticky per-counter overflow interrupt, enabled by defining COUNTER_OVERFLOW_IRQ_EN.
module csr_counter_bank #(
  parameter int NUM_HPM   = 4,
  parameter int COUNTER_W = 64,
  parameter int RETIRE_W  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     csr_valid,
  input  logic [11:0]                              csr_addr,
  input  logic [1:0]                               csr_op,
  input  logic [31:0]                              csr_wdata,
  output logic [31:0]                              csr_rdata,
  output logic                                     csr_rdata_valid,
  output logic                                     csr_illegal,
  input  logic [RETIRE_W-1:0]                      instret_inc,
  input  logic [((NUM_HPM < 1) ? 1 : NUM_HPM)-1:0] hpm_event,
  output logic                                     overflow_irq
);

  // Slot 1 (TIME) is never mapped; it stays zero and keeps indices equal to CSR offsets.
  localparam int          NUM_CNT   = 3 + NUM_HPM;
  localparam logic [5:0]  NUM_CNT_L = 6'(NUM_CNT);
  localparam logic [1:0]  CSR_RW    = 2'b01;
  localparam logic [1:0]  CSR_RS    = 2'b10;
  localparam logic [1:0]  CSR_RC    = 2'b11;
  localparam logic [31:0] INH_MASK  = 32'h0000_0005 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [COUNTER_W-1:0] cnt_q   [NUM_CNT];
  logic [COUNTER_W-1:0] cnt_d   [NUM_CNT];
  logic [COUNTER_W-1:0] inc_amt [NUM_CNT];
  logic [NUM_CNT-1:0]   wr_hit;
  logic [31:0]          inhibit_q, inhibit_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rdata_valid_q, rdata_valid_d;
  logic                 illegal_q, illegal_d;

  logic [4:0]           idx;
  logic                 hi, in_cnt_space, in_shadow_space, is_inh, idx_ok, illegal, do_write;
  logic [COUNTER_W-1:0] sel_cnt, wval;
  logic [63:0]          sel_ext, write_full;
  logic [31:0]          old_half, new_half;

  // Address decode, legality, read mux and write-value formation.
  always_comb begin
    idx             = csr_addr[4:0];
    hi              = csr_addr[7];
    in_cnt_space    = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00);
    in_shadow_space = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00);
    is_inh          = (csr_addr == 12'h320);
    idx_ok          = (idx == 5'd0) || (idx == 5'd2) ||
                      ((idx >= 5'd3) && ({1'b0, idx} < NUM_CNT_L));
    illegal         = (csr_op == 2'b00) ||
                      !(is_inh || ((in_cnt_space || in_shadow_space) && idx_ok)) ||
                      (in_shadow_space && ((csr_op == CSR_RW) || (csr_wdata != 32'd0)));
    // Set/clear with an all-zero mask is a pure read and must not suppress counting.
    do_write        = csr_valid && !illegal && !in_shadow_space &&
                      ((csr_op == CSR_RW) || (csr_wdata != 32'd0));
    sel_cnt = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      sel_cnt = (idx == 5'(i)) ? cnt_q[i] : sel_cnt;
    end
    sel_ext  = 64'(sel_cnt);
    old_half = is_inh ? inhibit_q : (hi ? sel_ext[63:32] : sel_ext[31:0]);
    case (csr_op)
      CSR_RW:  new_half = csr_wdata;
      CSR_RS:  new_half = old_half | csr_wdata;
      CSR_RC:  new_half = old_half & ~csr_wdata;
      default: new_half = old_half;
    endcase
    write_full    = hi ? {new_half, sel_ext[31:0]} : {sel_ext[63:32], new_half};
    wval          = COUNTER_W'(write_full);
    inhibit_d     = (do_write && is_inh) ? (new_half & INH_MASK) : inhibit_q;
    rdata_d       = (csr_valid && !illegal) ? old_half : 32'd0;
    rdata_valid_d = csr_valid;
    illegal_d     = csr_valid && illegal;
  end

  // Per-counter increment amount after inhibit gating.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      inc_amt[i] = '0;
    end
    inc_amt[0] = inhibit_q[0] ? '0 : COUNTER_W'(1'b1);
    inc_amt[2] = inhibit_q[2] ? '0 : COUNTER_W'(instret_inc);
    for (int i = 0; i < NUM_HPM; i++) begin
      inc_amt[3+i] = inhibit_q[3+i] ? '0 : COUNTER_W'(hpm_event[i]);
    end
  end

  // Next counter values: a write replaces the whole counter and suppresses that cycle's increment.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      wr_hit[i] = do_write && !is_inh && (idx == 5'(i));
      cnt_d[i]  = wr_hit[i] ? wval : (cnt_q[i] + inc_amt[i]);
    end
  end

  // State and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
      inhibit_q     <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      inhibit_q     <= inhibit_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      illegal_q     <= illegal_d;
    end
  end

  assign csr_rdata       = rdata_q;
  assign csr_rdata_valid = rdata_valid_q;
  assign csr_illegal     = illegal_q;

`ifdef COUNTER_OVERFLOW_IRQ_EN
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [COUNTER_W:0] ovf_sum;
  logic               irq_q, irq_d;

  // Sticky flags set by the carry out of the increment; a write to the counter clears and wins.
  always_comb begin
    ovf_d   = ovf_q;
    ovf_sum = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      ovf_sum  = {1'b0, cnt_q[i]} + {1'b0, inc_amt[i]};
      ovf_d[i] = wr_hit[i] ? 1'b0 : (ovf_q[i] | ovf_sum[COUNTER_W]);
    end
    irq_d = |ovf_d;
  end

  // Flag and interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end

  assign overflow_irq = irq_q;
`else
  assign overflow_irq = 1'b0;
`endif

endmodule
